// File: rtl/comp_serial_nbit.sv
// comp_serial_nbit: serial MSB-first magnitude comparator, STEP bits per clock, unsigned/signed
// Optional COMP_SERIAL_EARLY_EXIT_EN: finish on the first differing chunk instead of always taking N cycles.
module comp_serial_nbit #(
    parameter int WIDTH = 8,
    parameter int STEP  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             a_lt_b
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);
    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {D_EQ, D_GT, D_LT} dec_t;
    state_t state_q, state_d;
    dec_t dec_q, dec_d, dec_n;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, msb;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] flags_q, flags_d;
    logic [STEP-1:0] ca, cb;
    logic done_q, done_d, fin;
    // next state: capture operands in IDLE (MSB flipped in signed mode), compare and shift one chunk per RUN cycle
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        msb     = {signed_mode, {(WIDTH-1){1'b0}}};
        ca      = sa_q[WIDTH-1 -: STEP];
        cb      = sb_q[WIDTH-1 -: STEP];
        dec_n   = (dec_q == D_EQ && ca != cb) ? ((ca > cb) ? D_GT : D_LT) : dec_q;
`ifdef COMP_SERIAL_EARLY_EXIT_EN
        fin     = (cnt_q == CW'(1)) || (dec_n != D_EQ);
`else
        fin     = (cnt_q == CW'(1));
`endif
        if (state_q == IDLE) begin
            if (start) begin
                sa_d    = a ^ msb;
                sb_d    = b ^ msb;
                dec_d   = D_EQ;
                cnt_d   = CW'(N);
                state_d = RUN;
            end
        end else begin
            dec_d = dec_n;
            sa_d  = sa_q << STEP;
            sb_d  = sb_q << STEP;
            cnt_d = cnt_q - CW'(1);
            if (fin) begin
                state_d = IDLE;
                done_d  = 1'b1;
                flags_d = {dec_n == D_EQ, dec_n == D_GT, dec_n == D_LT};
            end
        end
    end
    // state registers; reset aborts any operation and restores the EQ flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            dec_q   <= D_EQ;
            done_q  <= 1'b0;
            flags_q <= 3'b100;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
            flags_q <= flags_d;
        end
    end
    assign busy = (state_q == RUN);
    assign done = done_q;
    assign {a_eq_b, a_gt_b, a_lt_b} = flags_q;
endmodule

// File: tb/tb_comp_serial_nbit.sv
// tb_comp_serial_nbit: directed and random checks of comp_serial_nbit with a flag scoreboard
module tb_comp_serial_nbit;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, sm = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic busy, done, eq, gt, lt;
    logic s16 = 1'b0, s8 = 1'b0, sm_w = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [7:0] a88 = '0, b88 = '0;
    logic busy16, done16, eq16, gt16, lt16;
    logic busy8, done8, eq8, gt8, lt8;
    int checks = 0, errors = 0;
    bit chk_on = 1'b0;
    logic [2:0] q[$], q16[$], q88[$];
`ifdef COMP_SERIAL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    comp_serial_nbit #(.WIDTH(8), .STEP(2)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
        .busy(busy), .done(done), .a_eq_b(eq), .a_gt_b(gt), .a_lt_b(lt));
    comp_serial_nbit #(.WIDTH(16), .STEP(4)) dut16 (
        .clk(clk), .rst(rst), .start(s16), .signed_mode(sm_w), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .a_eq_b(eq16), .a_gt_b(gt16), .a_lt_b(lt16));
    comp_serial_nbit #(.WIDTH(8), .STEP(8)) dut88 (
        .clk(clk), .rst(rst), .start(s8), .signed_mode(sm_w), .a(a88), .b(b88),
        .busy(busy8), .done(done8), .a_eq_b(eq8), .a_gt_b(gt8), .a_lt_b(lt8));

    always #5 clk = ~clk;

    function automatic logic [2:0] model(logic [15:0] x, logic [15:0] y, int w, bit s);
        longint vx = longint'(x);
        longint vy = longint'(y);
        if (s && x[w-1]) vx = vx - (longint'(1) << w);
        if (s && y[w-1]) vy = vy - (longint'(1) << w);
        return {vx == vy, vx > vy, vx < vy};
    endfunction

    function automatic int el(int k);
        return EE ? k : 4;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [7:0] x, input logic [7:0] y, input bit s);
        a = x; b = y; sm = s; start = 1'b1;
        q.push_back(model({8'h0, x}, {8'h0, y}, 8, s));
        @(negedge clk);
        start = 1'b0; a = ~x; b = ~y; sm = ~s;
    endtask

    task automatic wait_done(input string tag, input int lat0, input int exp_lat);
        int lat = lat0;
        logic [2:0] e;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) break;
            check({tag, "_busy"}, 16'(busy), 16'h1);
        end
        check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
        e = q.pop_front();
        check({tag, "_flags"}, {13'h0, eq, gt, lt}, {13'h0, e});
        check({tag, "_idle"}, 16'(busy), 16'h0);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("onehot8", 16'($onehot({eq, gt, lt})), 16'h1);
            check("onehot16", 16'($onehot({eq16, gt16, lt16})), 16'h1);
            check("onehot88", 16'($onehot({eq8, gt8, lt8})), 16'h1);
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        check("rst_state", {11'h0, busy, done, eq, gt, lt}, 16'h0004);
        check("rst_state16", {11'h0, busy16, done16, eq16, gt16, lt16}, 16'h0004);
        go(8'hA5, 8'hA5, 1'b0);
        wait_done("t1_eq", 0, 4);
        go(8'h80, 8'h7F, 1'b0);
        wait_done("t2_uns", 0, el(1));
        repeat (10) begin
            @(negedge clk);
            check("t2_uns_hold", {12'h0, done, eq, gt, lt}, 16'h0002);
        end
        go(8'h80, 8'h7F, 1'b1);
        wait_done("t2_sgn", 0, el(1));
        repeat (10) begin
            @(negedge clk);
            check("t2_sgn_hold", {12'h0, done, eq, gt, lt}, 16'h0001);
        end
        go(8'h7F, 8'h80, 1'b1);
        wait_done("t2_sgn_rev", 0, el(1));
        go(8'h00, 8'hC0, 1'b0);
        wait_done("t3_early", 0, el(1));
        go(8'h10, 8'h20, 1'b0);
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4_ignored", 1, el(2));
        go(8'hFF, 8'h00, 1'b0);
        check("t4_prev_held", {13'h0, eq, gt, lt}, 16'h0001);
        wait_done("t4_back2back", 0, el(1));
        go(8'h01, 8'h02, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_abort", {11'h0, busy, done, eq, gt, lt}, 16'h0004);
        q.delete();
        repeat (6) begin
            @(negedge clk);
            check("t5_no_done", {12'h0, done, eq, gt, lt}, 16'h0004);
        end
        for (int i = 0; i < 2000; i++) begin
            int n = 0;
            bit d16 = 1'b0, d8 = 1'b0;
            sm_w = i[0];
            a16 = 16'($urandom); b16 = (i % 8 == 2) ? a16 : 16'($urandom);
            a88 = 8'($urandom); b88 = (i % 8 == 4) ? a88 : 8'($urandom);
            if (i % 16 == 6) b16 = {a16[15:4], ~a16[3:0]};
            q16.push_back(model(a16, b16, 16, sm_w));
            q88.push_back(model({8'h0, a88}, {8'h0, b88}, 8, sm_w));
            s16 = 1'b1; s8 = 1'b1;
            @(negedge clk);
            s16 = 1'b0; s8 = 1'b0;
            a16 = ~a16; a88 = ~a88; sm_w = ~sm_w;
            while (!(d16 && d8) && n < 40) begin
                @(negedge clk);
                n++;
                if (done16) begin
                    d16 = 1'b1;
                    check("rnd16", {13'h0, eq16, gt16, lt16}, {13'h0, q16.pop_front()});
                end
                if (done8) begin
                    d8 = 1'b1;
                    check("rnd88", {13'h0, eq8, gt8, lt8}, {13'h0, q88.pop_front()});
                    if (!EE) check("rnd88_lat", 16'(n), 16'h1);
                end
            end
            if (!(d16 && d8)) check("rnd_timeout", {14'h0, d16, d8}, 16'h3);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
